imem_load_ctrl: RTL

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

---
 rtl/imem_load_ctrl_pkg.sv | 16 +
 rtl/imem_load_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/imem_load_ctrl_pkg.sv
// Shared CPU definitions used by the instruction-memory load controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_load_ctrl_pkg;

  // Controller operating modes
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } imem_ld_state_e;

  // Word index -> byte address conversion (32-bit instruction words)
  localparam int unsigned WORD_SHIFT = 2;

endpackage : imem_load_ctrl_pkg

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller: streams loader words into an external
//   memory, then hands the memory over to the fetch stage for execution.
// Latency: writes and read-address muxing are combinational; state changes on the next clk edge.
// Backpressure: ld_ready is high only in LOAD while the memory has room; fetch is held via stall_o.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start_load                 one-cycle request to (re)program the memory
//   ld_valid/ld_data/ld_last   loader word stream, ld_ready accepts
//   pc_addr                    fetch byte address, passed to mem_raddr in RUN
//   mem_we/mem_waddr/mem_wdata memory write port
//   mem_raddr                  memory read address
//   stall_o, fetch_fault       fetch-stage hold and bad-PC indication
//   load_count, overflow       words written in last/current load, sticky overrun flag
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_load,
  input  logic                         ld_valid,
  input  logic [ADDR_WIDTH-1:0]        ld_data,
  input  logic                         ld_last,
  output logic                         ld_ready,
  input  logic [ADDR_WIDTH-1:0]        pc_addr,
  output logic                         mem_we,
  output logic [ADDR_WIDTH-1:0]        mem_waddr,
  output logic [ADDR_WIDTH-1:0]        mem_wdata,
  output logic [ADDR_WIDTH-1:0]        mem_raddr,
  output logic                         stall_o,
  output logic                         fetch_fault,
  output logic [$clog2(MEM_WORDS):0]   load_count,
  output logic                         overflow
);

  localparam int CW = $clog2(MEM_WORDS) + 1;
  localparam logic [CW-1:0] LP_FULL = CW'(MEM_WORDS);
  localparam logic [CW-1:0] LP_LAST = CW'(MEM_WORDS - 1);
  // One bit wider than the address so 4*MEM_WORDS cannot wrap for small ADDR_WIDTH
  localparam logic [ADDR_WIDTH:0] LP_BYTE_LIMIT = (ADDR_WIDTH+1)'(MEM_WORDS) << WORD_SHIFT;

  imem_ld_state_e r_state;
  imem_ld_state_e w_state_nxt;

  logic [CW-1:0]         r_load_count;
  logic                  r_overflow;
  logic                  w_accept;
  logic                  w_enter_load;
  logic                  w_last_slot;
  logic                  w_pc_bad;
  logic [ADDR_WIDTH-1:0] w_waddr;

  assign w_last_slot = (r_load_count == LP_LAST);
  assign w_waddr     = ADDR_WIDTH'(r_load_count) << WORD_SHIFT;
  assign w_pc_bad    = (pc_addr[1:0] != 2'b00) || ({1'b0, pc_addr} >= LP_BYTE_LIMIT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_enter_load = 1'b0;
    ld_ready     = 1'b0;
    stall_o      = 1'b1;
    mem_we       = 1'b0;
    fetch_fault  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_load) begin
          w_state_nxt  = LOAD;
          w_enter_load = 1'b1;
        end
      end
      LOAD: begin
        // start_load is deliberately not looked at here
        ld_ready = (r_load_count < LP_FULL);
        w_accept = ld_valid && ld_ready;
        mem_we   = w_accept;
        // Either the loader says this is the end, or the memory is now full
        if (w_accept && (ld_last || w_last_slot)) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        stall_o     = 1'b0;
        fetch_fault = w_pc_bad;
        if (start_load) begin
          w_state_nxt  = LOAD;
          w_enter_load = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Word counter doubles as the write pointer; it only advances on an accept,
  // and accepts stop at MEM_WORDS, so it saturates without extra logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_count <= '0;
      r_overflow   <= 1'b0;
    end else if (w_enter_load) begin
      r_load_count <= '0;
      r_overflow   <= 1'b0;
    end else if (w_accept) begin
      r_load_count <= r_load_count + 1'b1;
      if (w_last_slot && !ld_last) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign mem_waddr  = w_waddr;
  assign mem_wdata  = ld_data;
  assign mem_raddr  = (r_state == RUN) ? pc_addr : w_waddr;
  assign load_count = r_load_count;
  assign overflow   = r_overflow;

endmodule : imem_load_ctrl
